// File: rtl/glyph_pkg.sv
// Shared types and constants for the glyph capture block and its cell-index helper.
// Cells are 8x8 pixels; a glyph box is 4 columns by 5 rows of cells.
package glyph_pkg;

    localparam int CELL_SH = 3;
    localparam int GLYPH_W = 32;
    localparam int GLYPH_H = 40;
    localparam int NCELLS  = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Flat bitmap position of a cell: row-major, four cells per row.
    function automatic logic [4:0] cell_bit(input logic [2:0] row, input logic [1:0] col);
        return {row, 2'b00} + {3'b000, col};
    endfunction

endpackage

// File: rtl/glyph_cell_index.sv
// Combinational mapping of a scan pixel onto the glyph box anchored at (ox, oy).
// Shared with the renderer-side checkers, so it carries no state.
module glyph_cell_index
    import glyph_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [CW-1:0] ox,
    input  logic [CW-1:0] oy,
    output logic          in_box,
    output logic [2:0]    row,
    output logic [1:0]    col,
    output logic          row_ok
);

    logic [CW-1:0] x_end;
    logic [CW-1:0] y_end;

    // Box ends wrap at CW bits on purpose; an origin near the edge yields an empty box.
    assign x_end = ox + CW'(GLYPH_W);
    assign y_end = oy + CW'(GLYPH_H);

    assign in_box = (x > ox) && (x < x_end) && (y > oy) && (y < y_end);

    assign col    = x[CELL_SH+1:CELL_SH] - ox[CELL_SH+1:CELL_SH];
    assign row    = y[CELL_SH+2:CELL_SH] - oy[CELL_SH+2:CELL_SH];
    assign row_ok = (row <= 3'd4);

endmodule

// File: rtl/glyph_capture.sv
// Rebuilds the 4x5 cell bitmap and lit-pixel count of the glyph at (x0, y0)
// from one full frame of the (x, y, disp) scan stream.
module glyph_capture
    import glyph_pkg::*;
#(
    parameter int CW    = 10,
    parameter int CNT_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW-1:0]     x,
    input  logic [CW-1:0]     y,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic              disp,
    input  logic [CW-1:0]     x0,
    input  logic [CW-1:0]     y0,
    input  logic              start,
    output logic              busy,
    output logic              bitmap_valid,
    input  logic              bitmap_ready,
    output logic [NCELLS-1:0] bitmap,
    output logic [CNT_W-1:0]  pix_count
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] ox;
    logic [CW-1:0] oy;
    logic          arm;
    logic          acc_en;
    logic          acc;
    logic          frame_tick;
    logic          in_box;
    logic [2:0]    row;
    logic [1:0]    col;
    logic          row_ok;

    glyph_cell_index #(
        .CW (CW)
    ) u_index (
        .x      (x),
        .y      (y),
        .ox     (ox),
        .oy     (oy),
        .in_box (in_box),
        .row    (row),
        .col    (col),
        .row_ok (row_ok)
    );

    assign frame_tick = pix_valid && frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The arming frame_start pixel belongs to the captured frame; the closing one does not.
    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ARMED;
                    arm       = 1'b1;
                end
            end
            ARMED: begin
                if (frame_tick) begin
                    state_nxt = CAPTURE;
                    acc_en    = 1'b1;
                end
            end
            CAPTURE: begin
                if (frame_tick) begin
                    state_nxt = DONE;
                end else begin
                    acc_en = 1'b1;
                end
            end
            DONE: begin
                if (bitmap_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign acc = acc_en && pix_valid && in_box && disp && row_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox        <= '0;
            oy        <= '0;
            bitmap    <= '0;
            pix_count <= '0;
        end else if (arm) begin
            ox        <= x0;
            oy        <= y0;
            bitmap    <= '0;
            pix_count <= '0;
        end else if (acc) begin
            bitmap <= bitmap | (NCELLS'(1) << cell_bit(row, col));
            if (pix_count != {CNT_W{1'b1}}) begin
                pix_count <= pix_count + CNT_W'(1);
            end
        end
    end

    // Result handshake: bitmap_valid is high exactly in DONE, bitmap/pix_count are
    // frozen while it is high, and it only drops on the edge after bitmap_ready is seen.
    assign busy         = (state == ARMED) || (state == CAPTURE);
    assign bitmap_valid = (state == DONE);

endmodule

// File: tb/tb_glyph_capture.sv
// Randomised scoreboard bench for glyph_capture: a driver streams pixel frames,
// a reference model predicts each result, and a monitor checks every transfer.
module tb_glyph_capture;

    localparam int CW     = 10;
    localparam int CNT_W  = 11;
    localparam int CMOD   = 1 << CW;
    localparam int CMAX   = (1 << CNT_W) - 1;

    localparam int P_NONE   = 0;
    localparam int P_S      = 1;
    localparam int P_EDGE   = 2;
    localparam int P_POINT  = 3;
    localparam int P_ONES   = 4;
    localparam int P_RAND   = 5;
    localparam int P_ORIGIN = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [CW-1:0]     x = '0;
    logic [CW-1:0]     y = '0;
    logic              pix_valid = 1'b0;
    logic              frame_start = 1'b0;
    logic              disp = 1'b0;
    logic [CW-1:0]     x0 = '0;
    logic [CW-1:0]     y0 = '0;
    logic              start = 1'b0;
    logic              busy;
    logic              bitmap_valid;
    logic              bitmap_ready = 1'b0;
    logic [19:0]       bitmap;
    logic [CNT_W-1:0]  pix_count;

    glyph_capture #(
        .CW    (CW),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x            (x),
        .y            (y),
        .pix_valid    (pix_valid),
        .frame_start  (frame_start),
        .disp         (disp),
        .x0           (x0),
        .y0           (y0),
        .start        (start),
        .busy         (busy),
        .bitmap_valid (bitmap_valid),
        .bitmap_ready (bitmap_ready),
        .bitmap       (bitmap),
        .pix_count    (pix_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [19:0]      exp_bm_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];
    logic [19:0]      last_bm;
    logic [CNT_W-1:0] last_cnt;

    // Reference model state: origin of the glyph being captured and its running result.
    int          m_ox;
    int          m_oy;
    logic [19:0] m_bm;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_inside(input int px, input int py);
        int xe;
        int ye;
        xe = (m_ox + 32) % CMOD;
        ye = (m_oy + 40) % CMOD;
        return (px > m_ox) && (px < xe) && (py > m_oy) && (py < ye);
    endfunction

    task automatic model_pixel(input int px, input int py, input bit d);
        int r;
        int c;
        if (d && m_inside(px, py)) begin
            r = (((py / 8) - (m_oy / 8)) % 8 + 8) % 8;
            c = (((px / 8) - (m_ox / 8)) % 4 + 4) % 4;
            if (r <= 4) begin
                m_bm[r*4+c] = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
    endtask

    // Renderer stand-in: disp as a function of pixel position and glyph origin.
    function automatic bit pat_disp(input int pat, input int px, input int py);
        int r;
        int c;
        case (pat)
            P_S: begin
                if (px < m_ox || py < m_oy) return 1'b0;
                r = (py - m_oy) / 8;
                c = (px - m_ox) / 8;
                if (c > 3) return 1'b0;
                return (r == 0) || (r == 2) || (r == 4) || (r == 1 && c == 0) || (r == 3 && c == 3);
            end
            P_EDGE:   return (px == 64) || (px == 96) || (py == 80) || (py == 120);
            P_POINT:  return (px == 65) && (py == 81);
            P_ONES:   return 1'b1;
            P_RAND:   return 1'($urandom_range(0, 1));
            P_ORIGIN: return (px == 0) && (py == 0);
            default:  return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random idle cycles carry a random frame_start that must be ignored.
    task automatic send_pixel(input int px, input int py, input bit fs, input bit d);
        if ($urandom_range(0, 7) == 0) begin
            pix_valid   = 1'b0;
            x           = CW'($urandom);
            y           = CW'($urandom);
            frame_start = 1'($urandom_range(0, 1));
            disp        = 1'($urandom_range(0, 1));
            tick();
        end
        pix_valid   = 1'b1;
        x           = CW'(px);
        y           = CW'(py);
        frame_start = fs;
        disp        = d;
        tick();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        disp        = 1'b0;
    endtask

    task automatic do_start(input int ox, input int oy);
        m_ox  = ox;
        m_oy  = oy;
        m_bm  = '0;
        m_cnt = 0;
        x0    = CW'(ox);
        y0    = CW'(oy);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic scan_frame(input int pat, input int xs, input int ys, input int w, input int h,
                              input int stop_at, input int start_at, input int alt_x0);
        int n;
        int px;
        int py;
        bit d;
        n = 0;
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                if (n == stop_at) return;
                px = (xs + i) % CMOD;
                py = (ys + j) % CMOD;
                d  = pat_disp(pat, px, py);
                if (n == start_at) begin
                    start = 1'b1;
                    x0    = CW'(alt_x0);
                    y0    = CW'(alt_x0 + 100);
                end
                model_pixel(px, py, d);
                send_pixel(px, py, (n == 0), d);
                start = 1'b0;
                n++;
            end
        end
    endtask

    // Closing frame_start pixel: ends the capture without being counted.
    task automatic finish_capture(input int pat, input int xs, input int ys, input bit use_const,
                                  input logic [19:0] cbm, input int ccnt);
        check("busy_in_capture", 32'(busy), 32'd1);
        check("valid_before_close", 32'(bitmap_valid), 32'd0);
        last_bm  = use_const ? cbm : m_bm;
        last_cnt = use_const ? CNT_W'(ccnt) : CNT_W'(m_cnt);
        exp_bm_q.push_back(last_bm);
        exp_cnt_q.push_back(last_cnt);
        send_pixel(xs % CMOD, ys % CMOD, 1'b1, pat_disp(pat, xs % CMOD, ys % CMOD));
        check("valid_after_close", 32'(bitmap_valid), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    task automatic accept(input bit with_start);
        int waited;
        bitmap_ready = 1'b1;
        start        = with_start;
        x0           = CW'(300);
        waited       = 0;
        while (bitmap_valid && waited < 20) begin
            tick();
            start = 1'b0;
            waited++;
        end
        bitmap_ready = 1'b0;
        start        = 1'b0;
        check("accept_in_time", 32'(waited <= 1), 32'd1);
        check("valid_dropped", 32'(bitmap_valid), 32'd0);
        tick();
        check("idle_not_busy", 32'(busy), 32'd0);
        check("idle_hold_bitmap", 32'(bitmap), 32'(last_bm));
        check("idle_hold_count", 32'(pix_count), 32'(last_cnt));
    endtask

    task automatic run_capture(input int ox, input int oy, input int pat, input int xs, input int ys,
                               input int w, input int h, input bit use_const,
                               input logic [19:0] cbm, input int ccnt, input int start_at);
        do_start(ox, oy);
        scan_frame(pat, xs, ys, w, h, -1, start_at, 200);
        finish_capture(pat, xs, ys, use_const, cbm, ccnt);
    endtask

    // Monitor: every accepted result is compared against the oldest prediction.
    always @(negedge clk) begin
        logic [19:0]      e_bm;
        logic [CNT_W-1:0] e_cnt;
        if (rst_n && bitmap_valid && bitmap_ready) begin
            if (exp_bm_q.size() == 0) begin
                check("unexpected_result", 32'(bitmap), 32'hFFFF_FFFF);
            end else begin
                e_bm  = exp_bm_q.pop_front();
                e_cnt = exp_cnt_q.pop_front();
                check("result_bitmap", 32'(bitmap), 32'(e_bm));
                check("result_count", 32'(pix_count), 32'(e_cnt));
            end
        end
    end

    initial begin
        int rx;
        int ry;
        #1 rst_n = 1'b0;
        #21;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bitmap_valid), 32'd0);
        check("rst_bitmap", 32'(bitmap), 32'd0);
        check("rst_count", 32'(pix_count), 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // S glyph; start together with ready in DONE must not re-arm.
        run_capture(64, 80, P_S, 56, 72, 48, 56, 1'b1, 20'hF8F1F, 833, -1);
        accept(1'b1);

        // Frame boundary pixels.
        run_capture(0, 0, P_ORIGIN, 0, 0, 48, 56, 1'b1, 20'h0, 0, -1);
        accept(1'b0);
        run_capture(64, 80, P_POINT, 65, 81, 8, 3, 1'b1, 20'h00001, 1, -1);
        accept(1'b0);

        // Strict box bounds, then the first interior pixel.
        run_capture(64, 80, P_EDGE, 56, 72, 48, 56, 1'b1, 20'h0, 0, -1);
        accept(1'b0);
        run_capture(64, 80, P_POINT, 56, 72, 48, 56, 1'b1, 20'h00001, 1, -1);
        accept(1'b0);

        // Backpressure with a different stream still running.
        run_capture(64, 80, P_S, 56, 72, 48, 56, 1'b1, 20'hF8F1F, 833, -1);
        for (int k = 0; k < 100; k++) begin
            pix_valid   = 1'b1;
            x           = CW'($urandom_range(65, 95));
            y           = CW'($urandom_range(81, 119));
            frame_start = (k % 25 == 0);
            disp        = 1'b1;
            start       = (k % 10 == 5);
            tick();
            check("bp_valid", 32'(bitmap_valid), 32'd1);
            check("bp_bitmap", 32'(bitmap), 32'hF8F1F);
            check("bp_count", 32'(pix_count), 32'd833);
        end
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        disp        = 1'b0;
        start       = 1'b0;
        accept(1'b0);

        // Asynchronous reset halfway through a capture.
        do_start(64, 80);
        scan_frame(P_S, 56, 72, 48, 56, 1344, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(bitmap_valid), 32'd0);
        check("abort_bitmap", 32'(bitmap), 32'd0);
        check("abort_count", 32'(pix_count), 32'd0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        run_capture(64, 80, P_S, 56, 72, 48, 56, 1'b1, 20'hF8F1F, 833, -1);
        accept(1'b0);

        // start during CAPTURE with another origin is ignored.
        run_capture(64, 80, P_S, 56, 72, 48, 56, 1'b1, 20'hF8F1F, 833, 1000);
        accept(1'b0);

        // Every box pixel lit.
        run_capture(64, 80, P_ONES, 56, 72, 48, 56, 1'b1, 20'hFFFFF, 1209, -1);
        accept(1'b0);

        // Revisiting one pixel drives the counter into saturation.
        do_start(64, 80);
        for (int k = 0; k < 2100; k++) begin
            model_pixel(70, 90, 1'b1);
            send_pixel(70, 90, (k == 0), 1'b1);
        end
        finish_capture(P_ONES, 70, 90, 1'b1, 20'h00010, CMAX);
        accept(1'b0);

        // Random origins (one at the coordinate wrap) and random disp.
        for (int t = 0; t < 5; t++) begin
            rx = (t == 0) ? 1010 : int'($urandom_range(0, CMOD - 1));
            ry = int'($urandom_range(0, CMOD - 1));
            run_capture(rx, ry, P_RAND, (rx + CMOD - 8) % CMOD, (ry + CMOD - 8) % CMOD, 48, 56,
                        1'b0, 20'h0, 0, -1);
            accept(1'b0);
        end

        check("queue_drained", 32'(exp_bm_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glyph_capture.md
Name: glyph_capture

Overview:
- Decoder-side counterpart of the per-letter glyph renderers. A renderer turns a pixel position and a glyph origin into a `disp` bit; this block runs the other way.
- It watches one full VGA frame of the (x, y, disp) pixel stream and rebuilds the 4x5 cell bitmap of the glyph at (x0, y0), along with a count of lit pixels.
- It sits beside the display scan and feeds the self-check and debug logic. The bitmap is returned through a valid/ready handshake.

Parameters:
- CW, 10: coordinate width (x, y, x0, y0).
- CELL_SH, 3: log2 of the cell size; cells are 8x8 pixels.
- GLYPH_W, 32: glyph box width in pixels (4 columns).
- GLYPH_H, 40: glyph box height in pixels (5 rows).
- CNT_W, 11: width of the lit-pixel counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- x  in  CW  current scan pixel column.
- y  in  CW  current scan pixel row.
- pix_valid  in  1  pixel tick; x, y and disp are meaningful only when this is 1.
- frame_start  in  1  marks the first pixel of a frame; sampled together with pix_valid.
- disp  in  1  rendered glyph pixel under test.
- x0  in  CW  glyph origin column; latched on start.
- y0  in  CW  glyph origin row; latched on start.
- start  in  1  request one capture; only honoured in IDLE.
- busy  out  1  high in ARMED and CAPTURE.
- bitmap_valid  out  1  result available.
- bitmap_ready  in  1  consumer accepts the result.
- bitmap  out  20  lit-cell mask, bit index = row*4 + col.
- pix_count  out  CNT_W  number of lit pixels inside the box.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - busy = 0, bitmap_valid = 0, bitmap = 0, pix_count = 0.
  - Latched origin = 0.
  - Asserting reset in any state aborts the capture immediately, with no partial result.
- Inside test, combinational on the latched origin (ox, oy):
  - in = (x > ox) && (x < ox + GLYPH_W) && (y > oy) && (y < oy + GLYPH_H).
  - Comparisons are unsigned at CW bits; ox + GLYPH_W truncates to CW bits, with no special handling.
- Cell index:
  - col = x[4:3] - ox[4:3], taken mod 4.
  - row = y[5:3] - oy[5:3], taken mod 8.
  - A pixel with row > 4 is dropped even when in = 1.
- Accumulate qualifier: acc = pix_valid && in && disp && (row <= 4).
  - When acc is 1, set bitmap[row*4 + col].
  - When acc is 1, increment pix_count, saturating at 2^CNT_W - 1.
- FSM:
  - IDLE: on start, latch x0/y0 into ox/oy, clear bitmap and pix_count, go to ARMED. In the cycle after start, busy = 1.
  - ARMED: wait for pix_valid && frame_start, then go to CAPTURE. The pixel in that same cycle is accumulated.
  - CAPTURE: accumulate on each acc.
    - On pix_valid && frame_start, go to DONE; that pixel is NOT accumulated, because it belongs to the next frame.
    - In the DONE transition cycle, bitmap_valid rises on the next edge.
  - DONE: busy = 0 and bitmap_valid = 1. bitmap and pix_count are held stable while valid. On bitmap_ready, go to IDLE and drop bitmap_valid next cycle.
- Handshake:
  - bitmap_valid is never withdrawn without bitmap_ready.
  - bitmap and pix_count hold their values in IDLE after the transfer, until the next start.
- Simultaneous events:
  - start in DONE is ignored, even if bitmap_ready is in the same cycle. The consumer must re-issue start in IDLE.
  - start in ARMED or CAPTURE is ignored.
  - frame_start without pix_valid is ignored.
- Latency: a result appears exactly one frame (one frame_start-to-frame_start span) after arming completes.

Decomposition:
- Shared package glyph_pkg:
  - state typedef {IDLE, ARMED, CAPTURE, DONE}.
  - Constants GLYPH_W, GLYPH_H, CELL_SH, and NCELLS = 20.
  - Function cell_bit(row, col) returning row*4 + col.
- One sub-module, glyph_cell_index: purely combinational. Takes x, y, ox, oy and returns in, row, col, and row_ok. The same logic can be reused by the renderer-side checkers.

Test Plan:
1. S glyph, full frame. Origin x0=64, y0=80; disp driven by the S cell pattern (rows 0, 2, 4 full; row 1 col 0; row 3 col 3). Run the 640x480 scan with start, then two frame_starts -> bitmap = 0xF8F1F, pix_count = 833, bitmap_valid held until bitmap_ready.
2. Frame boundary. disp = 1 only at the pixel that carries the second frame_start (x=0, y=0 with the origin at 0,0) -> that pixel is excluded; bitmap = 0, pix_count = 0.
3. Strict-bound edges. Origin (64, 80); disp = 1 only at x=64, at x=96, at y=80 and at y=120 -> all rejected; bitmap = 0. Then x=65, y=81 -> bitmap = 0x00001, pix_count = 1.
4. Backpressure. Hold bitmap_ready = 0 for 100 cycles after DONE while the scan continues with a different disp -> bitmap and pix_count unchanged, bitmap_valid stays 1; ready = 1 -> IDLE next cycle.
5. Reset mid-CAPTURE. Assert rst_n = 0 asynchronously, between clock edges, halfway through the frame -> all outputs 0 immediately; after release, a new start yields a clean result identical to scenario 1.
6. Ignored requests. start pulsed during CAPTURE with a different x0 -> the origin is not re-latched and the result matches scenario 1. An all-ones disp over the full box -> pix_count = 1209, bitmap = 0xFFFFF.
